// File: rtl/alarm_pkg.sv
// Shared constants and helpers for the alarm generator and its
// interrupt controller.
package alarm_pkg;

    localparam int NB_CAPTURES_DEF    = 10;
    localparam int TIMER_BITWIDTH_DEF = 32;
    localparam int CNT_BITWIDTH_DEF   = 8;

    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/alarm_prio_enc.sv
// Lowest-index-first combinational priority encoder over the
// pending-and-unmasked alarm channels.
module alarm_prio_enc
    import alarm_pkg::*;
#(
    parameter int NB_CAPTURES = NB_CAPTURES_DEF,
    parameter int ID_BITWIDTH = clog2_min1(NB_CAPTURES)
) (
    input  logic [NB_CAPTURES-1:0] req,
    output logic                   valid,
    output logic [ID_BITWIDTH-1:0] id
);

    always_comb begin
        valid = |req;
        id    = '0;
        // Scan downward so the lowest set index is written last.
        for (int i = NB_CAPTURES - 1; i >= 0; i--) begin
            if (req[i]) begin
                id = ID_BITWIDTH'(i);
            end
        end
    end

endmodule

// File: rtl/alarm_irq_ctrl.sv
// Turns alarm levels into sticky status/overrun flags, saturating
// event counters and one registered, masked interrupt.
module alarm_irq_ctrl
    import alarm_pkg::*;
#(
    parameter int NB_CAPTURES  = NB_CAPTURES_DEF,
    parameter int CNT_BITWIDTH = CNT_BITWIDTH_DEF,
    parameter int ID_BITWIDTH  = clog2_min1(NB_CAPTURES)
) (
    input  logic                              clk_i,
    input  logic                              rst_an_i,
    input  logic [NB_CAPTURES-1:0]            alarm_i,
    input  logic [NB_CAPTURES-1:0]            irq_mask_i,
    input  logic [NB_CAPTURES-1:0]            clear_i,
    output logic [NB_CAPTURES-1:0]            status_o,
    output logic [NB_CAPTURES-1:0]            overrun_o,
    output logic [NB_CAPTURES*CNT_BITWIDTH-1:0] event_cnt_o,
    output logic                              irq_o,
    output logic [ID_BITWIDTH-1:0]            irq_id_o
);

    logic [NB_CAPTURES-1:0] alarm_d;
    logic [NB_CAPTURES-1:0] rise;
    logic [NB_CAPTURES-1:0] status_q;
    logic [NB_CAPTURES-1:0] status_nxt;
    logic [NB_CAPTURES-1:0] overrun_q;
    logic [NB_CAPTURES-1:0] overrun_nxt;
    logic                   prio_valid;
    logic [ID_BITWIDTH-1:0] prio_id;

    assign rise = alarm_i & ~alarm_d;

    // Set beats clear; overrun only latches when the rise is not
    // acknowledged in the same cycle.
    always_comb begin
        status_nxt  = rise | (status_q & ~clear_i);
        overrun_nxt = overrun_q;
        for (int i = 0; i < NB_CAPTURES; i++) begin
            if (clear_i[i]) begin
                overrun_nxt[i] = 1'b0;
            end else if (rise[i] && status_q[i]) begin
                overrun_nxt[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_an_i) begin
        if (!rst_an_i) begin
            alarm_d   <= '0;
            status_q  <= '0;
            overrun_q <= '0;
        end else begin
            alarm_d   <= alarm_i;
            status_q  <= status_nxt;
            overrun_q <= overrun_nxt;
        end
    end

    for (genvar g = 0; g < NB_CAPTURES; g++) begin : g_cnt
        logic [CNT_BITWIDTH-1:0] cnt_q;

        always_ff @(posedge clk_i or negedge rst_an_i) begin
            if (!rst_an_i) begin
                cnt_q <= '0;
            end else if (clear_i[g]) begin
                cnt_q <= {{(CNT_BITWIDTH-1){1'b0}}, rise[g]};
            end else if (rise[g] && (cnt_q != '1)) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end

        assign event_cnt_o[g*CNT_BITWIDTH +: CNT_BITWIDTH] = cnt_q;
    end

    alarm_prio_enc #(
        .NB_CAPTURES (NB_CAPTURES),
        .ID_BITWIDTH (ID_BITWIDTH)
    ) u_prio (
        .req   (status_q & irq_mask_i),
        .valid (prio_valid),
        .id    (prio_id)
    );

    always_ff @(posedge clk_i or negedge rst_an_i) begin
        if (!rst_an_i) begin
            irq_o    <= 1'b0;
            irq_id_o <= '0;
        end else begin
            irq_o    <= prio_valid;
            irq_id_o <= prio_valid ? prio_id : '0;
        end
    end

    assign status_o  = status_q;
    assign overrun_o = overrun_q;

endmodule
